ipv4_parser: RTL and testbench

Second stage of the PL receive parser chain, directly downstream of the Ethernet header parser. It consumes that stage's registered byte stream and its `eth_type` field, and extracts the IPv4 header fields. It verifies the header checksum over the full IHL length and flags malformed or non-IPv4 frames. The byte stream is forwarded unchanged with one cycle of delay to the next (L4) stage.

---
 rtl/ipv4_parser.sv | 198 +++++++++++++++++++
 tb/tb_ipv4_parser.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_parser.sv
// IPv4 header parser: extracts header fields, verifies the header checksum,
// flags malformed/non-IPv4 frames and forwards the byte stream with one cycle of delay.
module ipv4_parser #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [DATA_WIDTH-1:0]                  tdata_in,
   input  logic [$clog2(DATA_WIDTH/8+1)-1:0]      idx_in,
   input  logic                                   data_valid_in,
   input  logic                                   last_flag_in,
   input  logic [15:0]                            eth_type,
   output logic [DATA_WIDTH-1:0]                  tdata_out,
   output logic [$clog2(DATA_WIDTH/8+1)-1:0]      idx_out,
   output logic                                   data_valid_out,
   output logic                                   last_flag_out,
   output logic                                   hdr_valid,
   output logic                                   hdr_error,
   output logic [3:0]                             error_code,
   output logic [3:0]                             ihl,
   output logic [7:0]                             ttl,
   output logic [7:0]                             protocol,
   output logic [15:0]                            total_length,
   output logic [31:0]                            src_ip,
   output logic [31:0]                            dst_ip
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(BYTES + 1);

   localparam logic [1:0] SKIP_ETH = 2'd0;
   localparam logic [1:0] IP_HDR   = 2'd1;
   localparam logic [1:0] PAYLOAD  = 2'd2;

   logic [1:0]  state_q, state_nxt, st_c;
   logic [6:0]  off_q, off_nxt;
   logic [7:0]  off_sum;
   logic [20:0] sum_q, sum_nxt, sum_c;
   logic [7:0]  hend_q, hend_nxt;
   logic        ver_bad_q, ver_bad_nxt;
   logic [7:0]  lane_off;
   logic [7:0]  lane_byte;
   logic        done_c, last_c, trunc_c, not_ip_c;
   logic [16:0] fold1_c;
   logic [15:0] fold2_c;
   logic [3:0]  code_done_c, code_trunc_c;

   logic [3:0]  ihl_nxt;
   logic [7:0]  ttl_nxt, protocol_nxt;
   logic [15:0] total_length_nxt;
   logic [31:0] src_ip_nxt, dst_ip_nxt;
   logic        hdr_valid_nxt, hdr_error_nxt;
   logic [3:0]  error_code_nxt;

   // Per-beat lane walk: state transitions, field capture, checksum and header result
   always_comb begin
      st_c             = state_q;
      sum_c            = sum_q;
      hend_nxt         = hend_q;
      ver_bad_nxt      = ver_bad_q;
      ihl_nxt          = ihl;
      ttl_nxt          = ttl;
      protocol_nxt     = protocol;
      total_length_nxt = total_length;
      src_ip_nxt       = src_ip;
      dst_ip_nxt       = dst_ip;
      done_c           = 1'b0;
      lane_off         = 8'd0;
      lane_byte        = 8'd0;

      for (int i = 0; i < int'(BYTES); i++) begin
         lane_off  = {1'b0, off_q} + 8'(i);
         lane_byte = tdata_in[i*8 +: 8];
         if (data_valid_in && (IDX_W'(i) < idx_in)) begin
            if ((st_c == SKIP_ETH) && (lane_off == 8'd14)) begin
               st_c = IP_HDR;
            end
            if (st_c == IP_HDR) begin
               if (lane_off == 8'd14) begin
                  ihl_nxt     = lane_byte[3:0];
                  ver_bad_nxt = (lane_byte[7:4] != 4'd4);
                  hend_nxt    = 8'd14 + {2'b00, (lane_byte[3:0] < 4'd5) ? 4'd5 : lane_byte[3:0], 2'b00};
               end
               case (lane_off)
                  8'd16:   total_length_nxt[15:8] = lane_byte;
                  8'd17:   total_length_nxt[7:0]  = lane_byte;
                  8'd22:   ttl_nxt                = lane_byte;
                  8'd23:   protocol_nxt           = lane_byte;
                  8'd26:   src_ip_nxt[31:24]      = lane_byte;
                  8'd27:   src_ip_nxt[23:16]      = lane_byte;
                  8'd28:   src_ip_nxt[15:8]       = lane_byte;
                  8'd29:   src_ip_nxt[7:0]        = lane_byte;
                  8'd30:   dst_ip_nxt[31:24]      = lane_byte;
                  8'd31:   dst_ip_nxt[23:16]      = lane_byte;
                  8'd32:   dst_ip_nxt[15:8]       = lane_byte;
                  8'd33:   dst_ip_nxt[7:0]        = lane_byte;
                  default: ;
               endcase
               // offset 14 is even, so the low offset bit selects low/high byte of the word
               sum_c = sum_c + (lane_off[0] ? 21'(lane_byte) : 21'({lane_byte, 8'h00}));
               if (lane_off == (hend_nxt - 8'd1)) begin
                  st_c   = PAYLOAD;
                  done_c = 1'b1;
               end
            end
         end
      end

      fold1_c      = 17'(sum_c[15:0]) + 17'(sum_c[20:16]);
      fold2_c      = fold1_c[15:0] + 16'(fold1_c[16]);
      not_ip_c     = ver_bad_nxt | (eth_type != 16'h0800);
      code_done_c  = {1'b0, (fold2_c != 16'hFFFF), (ihl_nxt < 4'd5), not_ip_c};
      code_trunc_c = {1'b1, 2'b00, (st_c == IP_HDR) & not_ip_c};
      last_c       = data_valid_in & last_flag_in;
      trunc_c      = last_c & (st_c != PAYLOAD);
   end

   // Next state, byte counter and checksum accumulator; a last beat rearms for the next frame
   always_comb begin
      state_nxt = state_q;
      off_nxt   = off_q;
      sum_nxt   = sum_q;
      off_sum   = {1'b0, off_q} + 8'(idx_in);
      if (last_c) begin
         state_nxt = SKIP_ETH;
         off_nxt   = 7'd0;
         sum_nxt   = 21'd0;
      end else if (data_valid_in) begin
         state_nxt = st_c;
         off_nxt   = (off_sum > 8'd127) ? 7'd127 : off_sum[6:0];
         sum_nxt   = sum_c;
      end
   end

   // Result flags: set at header end or truncation, held until the last beat has left
   always_comb begin
      hdr_valid_nxt  = hdr_valid;
      hdr_error_nxt  = hdr_error;
      error_code_nxt = error_code;
      if (done_c) begin
         hdr_valid_nxt  = (code_done_c == 4'd0);
         hdr_error_nxt  = (code_done_c != 4'd0);
         error_code_nxt = code_done_c;
      end else if (trunc_c) begin
         hdr_valid_nxt  = 1'b0;
         hdr_error_nxt  = 1'b1;
         error_code_nxt = code_trunc_c;
      end else if (data_valid_out && last_flag_out) begin
         hdr_valid_nxt  = 1'b0;
         hdr_error_nxt  = 1'b0;
         error_code_nxt = 4'd0;
      end
   end

   // State, parser context and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= SKIP_ETH;
         off_q          <= 7'd0;
         sum_q          <= 21'd0;
         hend_q         <= 8'd0;
         ver_bad_q      <= 1'b0;
         tdata_out      <= '0;
         idx_out        <= '0;
         data_valid_out <= 1'b0;
         last_flag_out  <= 1'b0;
         hdr_valid      <= 1'b0;
         hdr_error      <= 1'b0;
         error_code     <= 4'd0;
         ihl            <= 4'd0;
         ttl            <= 8'd0;
         protocol       <= 8'd0;
         total_length   <= 16'd0;
         src_ip         <= 32'd0;
         dst_ip         <= 32'd0;
      end else begin
         state_q        <= state_nxt;
         off_q          <= off_nxt;
         sum_q          <= sum_nxt;
         hend_q         <= hend_nxt;
         ver_bad_q      <= ver_bad_nxt;
         tdata_out      <= tdata_in;
         idx_out        <= idx_in;
         data_valid_out <= data_valid_in;
         last_flag_out  <= last_flag_in;
         hdr_valid      <= hdr_valid_nxt;
         hdr_error      <= hdr_error_nxt;
         error_code     <= error_code_nxt;
         ihl            <= ihl_nxt;
         ttl            <= ttl_nxt;
         protocol       <= protocol_nxt;
         total_length   <= total_length_nxt;
         src_ip         <= src_ip_nxt;
         dst_ip         <= dst_ip_nxt;
      end
   end

endmodule

// File: tb/tb_ipv4_parser.sv
// Table-driven bench for ipv4_parser: frame records with hand-computed results,
// plus hand-written reset sequences.
module tb_ipv4_parser;

   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned NB         = DATA_WIDTH / 8;
   localparam int unsigned IDX_W      = $clog2(NB + 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic [DATA_WIDTH-1:0] tdata_in;
   logic [IDX_W-1:0]      idx_in;
   logic                  data_valid_in;
   logic                  last_flag_in;
   logic [15:0]           eth_type;
   logic [DATA_WIDTH-1:0] tdata_out;
   logic [IDX_W-1:0]      idx_out;
   logic                  data_valid_out;
   logic                  last_flag_out;
   logic                  hdr_valid;
   logic                  hdr_error;
   logic [3:0]            error_code;
   logic [3:0]            ihl;
   logic [7:0]            ttl;
   logic [7:0]            protocol;
   logic [15:0]           total_length;
   logic [31:0]           src_ip;
   logic [31:0]           dst_ip;

   int n_cmp  = 0;
   int n_fail = 0;

   ipv4_parser #(.DATA_WIDTH(DATA_WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .tdata_in       (tdata_in),
      .idx_in         (idx_in),
      .data_valid_in  (data_valid_in),
      .last_flag_in   (last_flag_in),
      .eth_type       (eth_type),
      .tdata_out      (tdata_out),
      .idx_out        (idx_out),
      .data_valid_out (data_valid_out),
      .last_flag_out  (last_flag_out),
      .hdr_valid      (hdr_valid),
      .hdr_error      (hdr_error),
      .error_code     (error_code),
      .ihl            (ihl),
      .ttl            (ttl),
      .protocol       (protocol),
      .total_length   (total_length),
      .src_ip         (src_ip),
      .dst_ip         (dst_ip)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] eth;
      logic [7:0]  vihl;
      logic [7:0]  ck_hi;
      logic [7:0]  ck_lo;
      int          opts;      // option bytes after the 20-byte header
      int          pattern;   // 0: full beats, 1: idx 3,5,8,1 repeating
      int          len;       // frame length in bytes
      int          idle;      // idle cycles after the last beat
      logic        exp_ok;
      logic [3:0]  exp_code;
      int          exp_hend;
      logic [3:0]  exp_ihl;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " tdata_out"}, 64'(tdata_out), 64'd0);
      chk({tag, " idx_out"}, 64'(idx_out), 64'd0);
      chk({tag, " valid_out"}, 64'(data_valid_out), 64'd0);
      chk({tag, " last_out"}, 64'(last_flag_out), 64'd0);
      chk({tag, " hdr_valid"}, 64'(hdr_valid), 64'd0);
      chk({tag, " hdr_error"}, 64'(hdr_error), 64'd0);
      chk({tag, " error_code"}, 64'(error_code), 64'd0);
      chk({tag, " ihl"}, 64'(ihl), 64'd0);
      chk({tag, " ttl"}, 64'(ttl), 64'd0);
      chk({tag, " protocol"}, 64'(protocol), 64'd0);
      chk({tag, " total_length"}, 64'(total_length), 64'd0);
      chk({tag, " src_ip"}, 64'(src_ip), 64'd0);
      chk({tag, " dst_ip"}, 64'(dst_ip), 64'd0);
   endtask

   task automatic run_frame(input int r, input vec_t v);
      logic [7:0] fr [128];
      logic [7:0] hb [24];
      int sizes [128];
      int pat [4];
      int sent, k, n, rise, lastb;
      logic trunc, win;
      logic [DATA_WIDTH-1:0] d;

      pat = '{3, 5, 8, 1};
      hb  = '{v.vihl, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
              8'h40, 8'h11, v.ck_hi, v.ck_lo, 8'hc0, 8'ha8, 8'h00, 8'h01,
              8'hc0, 8'ha8, 8'h00, 8'hc7, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 128; i++) fr[i] = 8'(i * 7 + 3);
      for (int i = 0; i < 12; i++) fr[i] = 8'(8'hA0 + i);
      fr[12] = v.eth[15:8];
      fr[13] = v.eth[7:0];
      for (int i = 0; i < 20 + v.opts; i++) fr[14 + i] = hb[i];

      // beat plan and the beat holding byte hend-1
      sent = 0; k = 0; rise = -1;
      while (sent < v.len) begin
         n = (v.pattern == 1) ? pat[k % 4] : int'(NB);
         if (n > v.len - sent) n = v.len - sent;
         sizes[k] = n;
         if (rise < 0 && sent + n >= v.exp_hend) rise = k;
         sent += n;
         k++;
      end
      lastb = k - 1;
      trunc = (rise < 0);
      if (trunc) rise = lastb;

      eth_type = v.eth;
      sent = 0;
      for (int b = 0; b <= lastb + v.idle; b++) begin
         if (b <= lastb) begin
            for (int l = 0; l < int'(NB); l++)
               d[l*8 +: 8] = (l < sizes[b]) ? fr[sent + l] : 8'hEE;
            tdata_in      = d;
            idx_in        = IDX_W'(sizes[b]);
            data_valid_in = 1'b1;
            last_flag_in  = (b == lastb);
         end else begin
            tdata_in      = {NB{8'h5A}};
            idx_in        = IDX_W'(NB);
            data_valid_in = 1'b0;
            last_flag_in  = 1'b1;
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d b%0d tdata_out", r, b), 64'(tdata_out), 64'(tdata_in));
         chk($sformatf("v%0d b%0d idx_out", r, b), 64'(idx_out), 64'(idx_in));
         chk($sformatf("v%0d b%0d valid_out", r, b), 64'(data_valid_out), 64'(data_valid_in));
         chk($sformatf("v%0d b%0d last_out", r, b), 64'(last_flag_out), 64'(last_flag_in));
         win = (b >= rise) && (b <= lastb);
         chk($sformatf("v%0d b%0d hdr_valid", r, b), 64'(hdr_valid), 64'(win && v.exp_ok));
         chk($sformatf("v%0d b%0d hdr_error", r, b), 64'(hdr_error), 64'(win && !v.exp_ok));
         if (win && !v.exp_ok)
            chk($sformatf("v%0d b%0d error_code", r, b), 64'(error_code), 64'(v.exp_code));
         if (b == rise && !trunc) begin
            chk($sformatf("v%0d ihl", r), 64'(ihl), 64'(v.exp_ihl));
            chk($sformatf("v%0d total_length", r), 64'(total_length), 64'h0073);
            chk($sformatf("v%0d ttl", r), 64'(ttl), 64'h40);
            chk($sformatf("v%0d protocol", r), 64'(protocol), 64'h11);
            chk($sformatf("v%0d src_ip", r), 64'(src_ip), 64'hC0A80001);
            chk($sformatf("v%0d dst_ip", r), 64'(dst_ip), 64'hC0A800C7);
         end
         if (b <= lastb) sent += sizes[b];
      end
   endtask

   initial begin
      //             eth       vihl   ckhi   cklo  opt pat len idle ok    code   hend ihl
      vecs[0]  = '{16'h0800, 8'h45, 8'hb8, 8'h61, 0, 0, 64, 2, 1'b1, 4'b0000, 34, 4'd5};
      vecs[1]  = '{16'h0800, 8'h45, 8'hb8, 8'h62, 0, 0, 64, 2, 1'b0, 4'b0100, 34, 4'd5};
      vecs[2]  = '{16'h86DD, 8'h45, 8'hb8, 8'h61, 0, 0, 64, 2, 1'b0, 4'b0001, 34, 4'd5};
      vecs[3]  = '{16'h0800, 8'h46, 8'hb7, 8'h61, 4, 0, 64, 2, 1'b1, 4'b0000, 38, 4'd6};
      vecs[4]  = '{16'h0800, 8'h46, 8'hb7, 8'h61, 4, 1, 64, 2, 1'b1, 4'b0000, 38, 4'd6};
      vecs[5]  = '{16'h0800, 8'h44, 8'hb9, 8'h61, 0, 0, 64, 2, 1'b0, 4'b0010, 34, 4'd4};
      vecs[6]  = '{16'h0800, 8'h65, 8'h98, 8'h61, 0, 0, 64, 2, 1'b0, 4'b0001, 34, 4'd5};
      vecs[7]  = '{16'h0800, 8'h45, 8'hb8, 8'h61, 0, 0, 26, 0, 1'b0, 4'b1000, 34, 4'd5};
      vecs[8]  = '{16'h0800, 8'h45, 8'hb8, 8'h61, 0, 0, 64, 2, 1'b1, 4'b0000, 34, 4'd5};
      vecs[9]  = '{16'h86DD, 8'h45, 8'hb8, 8'h61, 0, 1, 26, 2, 1'b0, 4'b1001, 34, 4'd5};
      vecs[10] = '{16'h86DD, 8'h45, 8'hb8, 8'h61, 0, 0, 10, 2, 1'b0, 4'b1000, 34, 4'd5};

      // power-on reset with live-looking inputs: outputs must still be zero
      rst           = 1'b1;
      tdata_in      = 64'h0123_4567_89AB_CDEF;
      idx_in        = IDX_W'(NB);
      data_valid_in = 1'b1;
      last_flag_in  = 1'b1;
      eth_type      = 16'h0800;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_all_zero("por");
      rst           = 1'b0;
      data_valid_in = 1'b0;
      last_flag_in  = 1'b0;
      @(posedge clk); #1;

      for (int r = 0; r < 11; r++) run_frame(r, vecs[r]);

      // reset arriving with the beat after offset 20 has been consumed
      eth_type = 16'h0800;
      for (int b = 0; b < 3; b++) begin
         tdata_in      = {NB{8'(8'h10 + b)}};
         idx_in        = IDX_W'(NB);
         data_valid_in = 1'b1;
         last_flag_in  = 1'b0;
         @(posedge clk); #1;
      end
      rst           = 1'b1;
      tdata_in      = 64'hFEDC_BA98_7654_3210;
      @(posedge clk); #1;
      chk_all_zero("midrst");
      rst           = 1'b0;
      data_valid_in = 1'b0;
      @(posedge clk); #1;
      run_frame(11, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
